// File: rtl/ff_pkg.sv
// ff_pkg: shared mode encodings and defaults for the universal flip-flop register
package ff_pkg;

   localparam logic [1:0] MODE_D  = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_JK = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/univ_ff_bit.sv
// univ_ff_bit: one D/T/JK/SR bit built on a T-flip-flop core
module univ_ff_bit
   import ff_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   output logic       q,
   output logic       t,
   output logic       illegal
);

   logic q_q, q_d;

   // decode the requested next state; JK toggles and SR holds on a=b=1
   always_comb begin
      q_d = !en                ? q_q :
            (mode == MODE_D)   ? a :
            (mode == MODE_T)   ? q_q ^ a :
            (a && b)           ? ((mode == MODE_JK) ? ~q_q : q_q) :
            a                  ? 1'b1 :
            b                  ? 1'b0 : q_q;
      t       = q_d ^ q_q;
      illegal = en && (mode == MODE_SR) && a && b;
   end

   // T-core: the bit only ever toggles by t
   always_ff @(posedge clk) begin
      if (rst) q_q <= 1'b0;
      else     q_q <= q_q ^ t;
   end

   assign q = q_q;

endmodule

// File: rtl/univ_ff_reg.sv
// univ_ff_reg: WIDTH-bit run-time-selectable flip-flop register with toggle mask, sticky SR error and change counter
module univ_ff_reg
   import ff_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             err_clr,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_bar,
   output logic [WIDTH-1:0] toggled,
   output logic [WIDTH-1:0] err,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] t, illegal;
   logic [WIDTH-1:0] toggled_q, err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             inc;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      univ_ff_bit u_bit (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .mode    (mode),
         .a       (A[i]),
         .b       (B[i]),
         .q       (Q[i]),
         .t       (t[i]),
         .illegal (illegal[i])
      );
   end

   // illegal SR beats a clear; counter restarts at 1 when cleared on a changing edge
   always_comb begin
      inc   = |t;
      err_d = illegal | (err_clr ? '0 : err_q);
      cnt_d = cnt_clr                       ? {{(CNT_W-1){1'b0}}, inc} :
              (inc && (cnt_q != CNT_MAX))   ? cnt_q + 1'b1 : cnt_q;
   end

   // side-band state: toggle mask, sticky errors, change counter
   always_ff @(posedge clk) begin
      if (rst) begin
         toggled_q <= '0;
         err_q     <= '0;
         cnt_q     <= '0;
      end else begin
         toggled_q <= t;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign Q_bar   = ~Q;
   assign toggled = toggled_q;
   assign err     = err_q;
   assign chg_cnt = cnt_q;

endmodule
